// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus. The controller (slave) receives pipeline hazard sources
// and drives the per-stage enable/flush strobes back to the pipeline (master).
interface pipeline_hazard_controller_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_reg_write_addr;
  logic        ex_data_mem_read;
  logic        ex_muldiv;
  logic        ex_branch_taken;
  logic        imem_busywait;
  logic        dmem_busywait;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        muldiv_busy;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_reg_write_addr, ex_data_mem_read, ex_muldiv, ex_branch_taken,
           imem_busywait, dmem_busywait,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, muldiv_busy, stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_reg_write_addr, ex_data_mem_read, ex_muldiv, ex_branch_taken,
           imem_busywait, dmem_busywait,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, muldiv_busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: prioritises DMEM busywait,
// MUL/DIV hold, taken branch, load-use and IMEM busywait; counts PC-stall cycles.
module pipeline_hazard_controller #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 32;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   md_count_q, md_count_d;
  logic [STALL_W-1:0] stall_q;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic load_use;

  // rd = x0 never creates a real dependency
  assign load_use = bus.ex_data_mem_read
                 && (bus.ex_reg_write_addr != 5'd0)
                 && ((bus.id_rs1_used && (bus.id_rs1_addr == bus.ex_reg_write_addr))
                  || (bus.id_rs2_used && (bus.id_rs2_addr == bus.ex_reg_write_addr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      md_count_q <= '0;
    end else begin
      state_q    <= state_d;
      md_count_q <= md_count_d;
    end
  end

  // Highest-priority active condition alone decides strobes and next state
  always_comb begin
    state_d      = state_q;
    md_count_d   = md_count_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (bus.dmem_busywait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (state_q == MULDIV) begin
      if (md_count_q != '0) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
        md_count_d   = md_count_q - CNT_W'(1);
      end else begin
        state_d = RUN;
      end
    end else if (bus.ex_muldiv) begin
      // First stall cycle is spent here in RUN, hence the load of CYCLES-1
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = MULDIV;
      md_count_d   = MD_LOAD;
    end else if (bus.ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.imem_busywait) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Free-running performance counter of PC-frozen cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.muldiv_busy  = (state_q == MULDIV);
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: per-cycle comparison against a
// rule-level model plus hand-computed literal expectations for each scenario.
module tb_pipeline_hazard_controller;

  localparam int unsigned MD = 4;
  // Strobe vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl}
  localparam logic [7:0] DEF = 8'b11111_000;
  localparam logic [7:0] DMS = 8'b00000_000;
  localparam logic [7:0] MDS = 8'b00001_001;
  localparam logic [7:0] BRS = 8'b11111_110;
  localparam logic [7:0] LUS = 8'b00111_010;
  localparam logic [7:0] IMS = 8'b01111_100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(.MULDIV_CYCLES(MD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (hz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: whether a MUL/DIV is in flight and how many stall cycles it has used
  bit          m_in_md   = 1'b0;
  int          m_done    = 0;
  logic [31:0] m_stall   = 32'd0;
  bit          chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_strobes();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
            hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush};
  endfunction

  function automatic bit model_load_use();
    bit r1, r2;
    r1 = hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_reg_write_addr);
    r2 = hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_reg_write_addr);
    return hz.ex_data_mem_read && (hz.ex_reg_write_addr != 5'd0) && (r1 || r2);
  endfunction

  function automatic logic [7:0] model_strobes();
    if (hz.dmem_busywait)       return DMS;
    if (m_in_md)                return (m_done < int'(MD)) ? MDS : DEF;
    if (hz.ex_muldiv)           return MDS;
    if (hz.ex_branch_taken)     return BRS;
    if (model_load_use())       return LUS;
    if (hz.imem_busywait)       return IMS;
    return DEF;
  endfunction

  // Model advance on each rising edge, from the rules rather than a counter FSM
  always @(posedge clk) begin
    logic [7:0] s;
    if (reset) begin
      m_in_md = 1'b0;
      m_done  = 0;
      m_stall = 32'd0;
      chk_en  = 1'b1;
    end else begin
      s = model_strobes();
      if (!s[7]) m_stall = m_stall + 32'd1;
      if (!hz.dmem_busywait) begin
        if (m_in_md) begin
          if (m_done < int'(MD)) m_done++;
          else m_in_md = 1'b0;
        end else if (hz.ex_muldiv) begin
          m_in_md = 1'b1;
          m_done  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_strobes", 32'(dut_strobes()), 32'(model_strobes()));
      check("model_busy", 32'(hz.muldiv_busy), 32'(m_in_md));
      check("model_stall", hz.stall_cycles, m_stall);
    end
  end

  task automatic clr();
    hz.id_rs1_addr       = 5'd0;
    hz.id_rs2_addr       = 5'd0;
    hz.id_rs1_used       = 1'b0;
    hz.id_rs2_used       = 1'b0;
    hz.ex_reg_write_addr = 5'd0;
    hz.ex_data_mem_read  = 1'b0;
    hz.ex_muldiv         = 1'b0;
    hz.ex_branch_taken   = 1'b0;
    hz.imem_busywait     = 1'b0;
    hz.dmem_busywait     = 1'b0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    hz.ex_data_mem_read  = 1'b1;
    hz.ex_reg_write_addr = rd;
    hz.id_rs1_addr       = rd;
    hz.id_rs1_used       = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    adv();
    // Reset held: state RUN, strobes default
    @(negedge clk);
    check("rst_strobes", 32'(dut_strobes()), 32'(DEF));
    check("rst_stall", hz.stall_cycles, 32'd0);
    check("rst_busy", 32'(hz.muldiv_busy), 32'd0);
    adv();
    reset = 1'b0;

    // Load-use via rs1, rd = 5
    clr(); load_use_rs1(5'd5);
    @(negedge clk);
    check("lu_rs1_strobes", 32'(dut_strobes()), 32'(LUS));
    check("lu_rs1_stall_before", hz.stall_cycles, 32'd0);
    adv();
    clr();
    @(negedge clk);
    check("lu_rs1_stall_after", hz.stall_cycles, 32'd1);
    adv();
    // rd = x0 never stalls
    clr(); load_use_rs1(5'd0);
    @(negedge clk);
    check("lu_rd0_strobes", 32'(dut_strobes()), 32'(DEF));
    adv();
    // rs2 dependency, used and then unused
    clr(); hz.ex_data_mem_read = 1'b1; hz.ex_reg_write_addr = 5'd7;
    hz.id_rs2_addr = 5'd7; hz.id_rs2_used = 1'b1; hz.id_rs1_addr = 5'd3; hz.id_rs1_used = 1'b1;
    @(negedge clk);
    check("lu_rs2_strobes", 32'(dut_strobes()), 32'(LUS));
    adv();
    hz.id_rs2_used = 1'b0;
    @(negedge clk);
    check("lu_rs2_unused", 32'(dut_strobes()), 32'(DEF));
    adv();
    clr();
    @(negedge clk);
    check("lu_stall_total", hz.stall_cycles, 32'd2);
    adv();

    // MUL/DIV: four stall cycles then a release cycle
    begin
      int stalls = 0;
      int busy_in_stall = 0;
      hz.ex_muldiv = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (!hz.pc_en) begin
          stalls++;
          if (hz.muldiv_busy) busy_in_stall++;
        end
        if (i < 4) check("md_stall_strobes", 32'(dut_strobes()), 32'(MDS));
        else       check("md_release_strobes", 32'(dut_strobes()), 32'(DEF));
        adv();
        clr();
      end
      check("md_stall_count", 32'(stalls), 32'd4);
      check("md_busy_count", 32'(busy_in_stall), 32'd3);
    end
    @(negedge clk);
    check("md_busy_after", 32'(hz.muldiv_busy), 32'd0);
    check("md_stall_total", hz.stall_cycles, 32'd6);
    adv();

    // DMEM busywait while MD_COUNT = 2 stretches the hold to 7 cycles
    hz.ex_muldiv = 1'b1;
    adv(); clr();
    adv();
    hz.dmem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("md_dmem_strobes", 32'(dut_strobes()), 32'(DMS));
      check("md_dmem_busy", 32'(hz.muldiv_busy), 32'd1);
      adv();
    end
    clr();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("md_dmem_resume", 32'(dut_strobes()), 32'(MDS));
      adv();
    end
    @(negedge clk);
    check("md_dmem_release", 32'(dut_strobes()), 32'(DEF));
    adv();
    @(negedge clk);
    check("md_dmem_stall_total", hz.stall_cycles, 32'd13);
    adv();

    // Branch outranks load-use and IMEM busywait
    clr(); load_use_rs1(5'd9); hz.imem_busywait = 1'b1; hz.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("br_priority", 32'(dut_strobes()), 32'(BRS));
    adv();
    hz.ex_branch_taken = 1'b0;
    @(negedge clk);
    check("lu_over_imem", 32'(dut_strobes()), 32'(LUS));
    adv();
    clr(); hz.imem_busywait = 1'b1;
    @(negedge clk);
    check("imem_strobes", 32'(dut_strobes()), 32'(IMS));
    adv();
    clr(); hz.dmem_busywait = 1'b1; hz.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("dmem_over_branch", 32'(dut_strobes()), 32'(DMS));
    adv();
    clr();
    @(negedge clk);
    check("mix_stall_total", hz.stall_cycles, 32'd16);
    adv();

    // Reset in MULDIV with MD_COUNT = 2 discards the pending hold
    hz.ex_muldiv = 1'b1;
    adv(); clr();
    adv();
    reset = 1'b1;
    @(negedge clk);
    check("rst_md_strobes", 32'(dut_strobes()), 32'(MDS));
    adv();
    reset = 1'b0;
    @(negedge clk);
    check("rst_md_busy", 32'(hz.muldiv_busy), 32'd0);
    check("rst_md_stall", hz.stall_cycles, 32'd0);
    check("rst_md_strobes_after", 32'(dut_strobes()), 32'(DEF));
    adv();

    // Counter wrap from 0xFFFFFFFE through five stall cycles
    force dut.stall_q = 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    @(negedge clk);
    check("wrap_preload", hz.stall_cycles, 32'hFFFF_FFFE);
    adv();
    hz.imem_busywait = 1'b1;
    for (int i = 0; i < 5; i++) adv();
    clr();
    @(negedge clk);
    check("wrap_value", hz.stall_cycles, 32'd3);
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
